// File: rtl/rotator_pkg.sv
// Shared constants for the sequential rotator: direction encodings and FSM states.
package rotator_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_rotator_rotate_step.sv
// One-position combinational rotate, used on the working-register feedback path.
module rotate_step
    import rotator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic             d,
    output logic [WIDTH-1:0] r
);

    assign r = (d == DIR_LEFT) ? {in[WIDTH-2:0], in[WIDTH-1]}
                               : {in[0], in[WIDTH-1:1]};

endmodule

// File: rtl/seq_rotator.sv
// Multi-cycle rotator: captures a word on start, rotates one bit per clock for
// amt cycles, then pulses done for one cycle with the result held in r.
module seq_rotator
    import rotator_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             d,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    state_t           state, state_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic             dir, dir_nxt;
    logic [WIDTH-1:0] r_nxt, r_rot;

    rotate_step #(.WIDTH(WIDTH)) u_step (
        .in (r),
        .d  (dir),
        .r  (r_rot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            r     <= '0;
            count <= '0;
            dir   <= DIR_RIGHT;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        count_nxt = count;
        dir_nxt   = dir;
        case (state)
            // DONE accepts a new start just like IDLE, so back-to-back ops have no bubble
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    r_nxt     = in;
                    dir_nxt   = d;
                    count_nxt = amt;
                    state_nxt = (amt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                r_nxt     = r_rot;
                count_nxt = count - 1'b1;
                if (count == AMT_W'(1))
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule
